// File: rtl/upstream_order_scheduler_if.sv
// Order request channels and upstream client RAM port.
// master = requesters plus RAM, slave = the scheduler.
interface upstream_order_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 5
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*IDX_W-1:0] req_client_id;
  logic [NUM_REQ*16-1:0]    req_amount;
  logic [NUM_REQ-1:0]       req_is_max;
  logic [15:0]              cancelled_orders;
  logic                     mem_req_valid;
  logic                     mem_req_rw;
  logic [IDX_W-1:0]         mem_index;
  logic [31:0]              mem_wdata;
  logic [31:0]              mem_rdata;
  logic                     mem_rd_ready;
  logic                     mem_written;
  logic                     resp_valid;
  logic [2:0]               resp_port;
  logic                     resp_pass;
  logic                     resp_err;
  logic                     check_risk;
  logic                     send_order;
  logic                     update_max;

  modport master (
    output req_valid, req_client_id, req_amount,
    output req_is_max, cancelled_orders,
    output mem_rdata, mem_rd_ready, mem_written,
    input  req_ready, mem_req_valid, mem_req_rw,
    input  mem_index, mem_wdata,
    input  resp_valid, resp_port, resp_pass, resp_err,
    input  check_risk, send_order, update_max
  );

  modport slave (
    input  req_valid, req_client_id, req_amount,
    input  req_is_max, cancelled_orders,
    input  mem_rdata, mem_rd_ready, mem_written,
    output req_ready, mem_req_valid, mem_req_rw,
    output mem_index, mem_wdata,
    output resp_valid, resp_port, resp_pass, resp_err,
    output check_risk, send_order, update_max
  );
endinterface

// File: rtl/upstream_order_scheduler.sv
// Round-robin scheduler running one read-check-write
// transaction per request against the upstream client RAM.
module upstream_order_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic HRESETn,
  upstream_order_scheduler_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_WRITE, S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [PW-1:0]    port_q, port_d;
  logic [PW-1:0]    gnt_idx, cand;
  logic             gnt_any;
  logic [IDX_W-1:0] id_q, id_d;
  logic [15:0]      amt_q, amt_d;
  logic [15:0]      acc_q, acc_d;
  logic [15:0]      max_q, max_d;
  logic             ismax_q, ismax_d;
  logic             pass_q, pass_d;
  logic             err_q, err_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             tmo_hit;
  logic [15:0]      result;
  logic             risk_ok;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(rr_q) + i) % NUM_REQ);
      if (!gnt_any && bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign result  = acc_q - bus.cancelled_orders + amt_q;
  // 17-bit signed compare: a wrapped-negative result always passes
  assign risk_ok = $signed({1'b0, max_q})
                 > $signed({result[15], result});

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (gnt_any) state_d = S_READ;
      S_READ: begin
        if (bus.mem_rd_ready) state_d = S_CHECK;
        else if (tmo_hit)     state_d = S_RESP;
      end
      S_CHECK: state_d = (ismax_q || risk_ok)
                       ? S_WRITE : S_RESP;
      S_WRITE: begin
        if (bus.mem_written || tmo_hit)
          state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_d    = rr_q;
    port_d  = port_q;
    id_d    = id_q;
    amt_d   = amt_q;
    ismax_d = ismax_q;
    acc_d   = acc_q;
    max_d   = max_q;
    pass_d  = pass_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: if (gnt_any) begin
        port_d  = gnt_idx;
        rr_d    = (gnt_idx == PW'(NUM_REQ - 1))
                ? '0 : gnt_idx + PW'(1);
        id_d    = bus.req_client_id[gnt_idx*IDX_W +: IDX_W];
        amt_d   = bus.req_amount[gnt_idx*16 +: 16];
        ismax_d = bus.req_is_max[gnt_idx];
        pass_d  = 1'b0;
        err_d   = 1'b0;
        tmo_d   = '0;
      end
      S_READ: begin
        if (bus.mem_rd_ready) begin
          acc_d = bus.mem_rdata[15:0];
          max_d = bus.mem_rdata[31:16];
        end else if (tmo_hit) begin
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CHECK: begin
        pass_d = ismax_q | risk_ok;
        tmo_d  = '0;
      end
      S_WRITE: if (!bus.mem_written) begin
        if (tmo_hit) begin
          err_d  = 1'b1;
          pass_d = 1'b0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      rr_q    <= '0;
      port_q  <= '0;
      id_q    <= '0;
      amt_q   <= '0;
      ismax_q <= 1'b0;
      acc_q   <= '0;
      max_q   <= '0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      port_q  <= port_d;
      id_q    <= id_d;
      amt_q   <= amt_d;
      ismax_q <= ismax_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    bus.req_ready     = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_rw    = 1'b0;
    bus.mem_index     = '0;
    bus.mem_wdata     = '0;
    bus.resp_valid    = 1'b0;
    bus.resp_port     = '0;
    bus.resp_pass     = 1'b0;
    bus.resp_err      = 1'b0;
    bus.check_risk    = 1'b0;
    bus.send_order    = 1'b0;
    bus.update_max    = 1'b0;
    unique case (state_q)
      S_IDLE: if (gnt_any && HRESETn)
        bus.req_ready[gnt_idx] = 1'b1;
      S_READ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_index     = id_q;
      end
      S_CHECK: bus.check_risk = 1'b1;
      S_WRITE: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b1;
        bus.mem_index     = id_q;
        bus.mem_wdata     = ismax_q
                          ? {amt_q, acc_q}
                          : {max_q, acc_q + amt_q};
        bus.send_order    = !ismax_q;
        bus.update_max    = ismax_q;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_port  = 3'(port_q);
        bus.resp_pass  = pass_q;
        bus.resp_err   = err_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_upstream_order_scheduler.sv
// Bench for upstream_order_scheduler: RAM responder,
// arbitration and risk model, directed and random scenarios.
module tb_upstream_order_scheduler;
  localparam int N   = 4;
  localparam int IW  = 5;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic HRESETn;
  always #5 clk = ~clk;

  upstream_order_scheduler_if #(.NUM_REQ(N), .IDX_W(IW)) bif ();

  upstream_order_scheduler #(
    .NUM_REQ(N), .IDX_W(IW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .HRESETn(HRESETn), .bus(bif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]   ram [32];
  int            lat     = 0;
  bit            ram_en  = 1'b1;
  bit            wr_en   = 1'b1;
  bit            inj_rd  = 1'b0;
  bit            inj_wr  = 1'b0;
  int            wr_cnt  = 0;
  int            lat_cnt = 0;
  int            rr_model = 0;
  logic [IW-1:0] ch_id  [N];
  logic [15:0]   ch_amt [N];
  logic          ch_max [N];

  // RAM: answers a held request after 'lat' extra cycles
  initial begin
    bif.mem_rd_ready = 1'b0;
    bif.mem_written  = 1'b0;
    bif.mem_rdata    = '0;
    forever begin
      @(negedge clk);
      bif.mem_rd_ready = inj_rd;
      bif.mem_written  = inj_wr;
      if (ram_en && HRESETn && bif.mem_req_valid
          && (wr_en || !bif.mem_req_rw)) begin
        if (lat_cnt >= lat) begin
          lat_cnt = 0;
          if (bif.mem_req_rw) begin
            ram[bif.mem_index] = bif.mem_wdata;
            wr_cnt++;
            bif.mem_written = 1'b1;
          end else begin
            bif.mem_rdata    = ram[bif.mem_index];
            bif.mem_rd_ready = 1'b1;
          end
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int exp_grant(input logic [N-1:0] m);
    int best, bd, d;
    best = -1;
    bd   = N;
    for (int c = 0; c < N; c++) begin
      if (m[c]) begin
        d = (c - rr_model + N) % N;
        if (d < bd) begin
          bd   = d;
          best = c;
        end
      end
    end
    return best;
  endfunction

  function automatic void model(
    input  logic [31:0] w,
    input  logic [15:0] canc,
    input  logic [15:0] amt,
    input  logic        ismax,
    output logic        pass,
    output logic [31:0] nw
  );
    int acc, mx, r;
    acc = int'(w[15:0]);
    mx  = int'(w[31:16]);
    if (ismax) begin
      pass = 1'b1;
      nw   = {amt, w[15:0]};
    end else begin
      r = (acc - int'(canc) + int'(amt)) % 65536;
      if (r < 0) r += 65536;
      if (r >= 32768) r -= 65536;
      pass = (mx > r);
      nw   = pass ? {w[31:16], 16'((acc + int'(amt)) % 65536)}
                  : w;
    end
  endfunction

  task automatic drive_req(input logic [N-1:0] m,
                           input logic [15:0] canc);
    bif.cancelled_orders = canc;
    for (int i = 0; i < N; i++) begin
      bif.req_client_id[i*IW +: IW] = ch_id[i];
      bif.req_amount[i*16 +: 16]    = ch_amt[i];
      bif.req_is_max[i]             = ch_max[i];
    end
    bif.req_valid = m;
  endtask

  task automatic do_reset();
    HRESETn       = 1'b0;
    bif.req_valid = '0;
    repeat (3) @(negedge clk);
    HRESETn  = 1'b1;
    rr_model = 0;
    @(negedge clk);
  endtask

  task automatic run_txn(
    input  logic [N-1:0] m,
    input  logic [15:0]  canc,
    output int           gnt,
    output int           cyc,
    output logic [2:0]   port,
    output logic         pass,
    output logic         err,
    output int           writes,
    output int           upd,
    output int           snd,
    output bit           bad,
    output bit           lost
  );
    int w0;
    gnt = -1; cyc = 0; port = '0; pass = 1'b0;
    err = 1'b0; upd = 0; snd = 0; bad = 1'b0;
    lost = 1'b0; writes = 0;
    w0 = wr_cnt;
    @(negedge clk);
    drive_req(m, canc);
    for (int c = 0; c < 60 && gnt < 0; c++) begin
      #1;
      if ($countones(bif.req_ready) > 1) bad = 1'b1;
      for (int i = 0; i < N; i++)
        if (bif.req_ready[i]) gnt = i;
      @(negedge clk);
    end
    bif.req_valid = '0;
    if (gnt < 0) begin
      lost = 1'b1;
      return;
    end
    lost = 1'b1;
    for (int c = 0; c < 100; c++) begin
      cyc++;
      if (bif.check_risk && (bif.send_order || bif.update_max))
        bad = 1'b1;
      if (bif.send_order && bif.update_max) bad = 1'b1;
      if ((bif.send_order || bif.update_max)
          && !(bif.mem_req_valid && bif.mem_req_rw))
        bad = 1'b1;
      if (bif.req_ready != '0) bad = 1'b1;
      if (bif.update_max) upd++;
      if (bif.send_order) snd++;
      if (bif.resp_valid) begin
        port = bif.resp_port;
        pass = bif.resp_pass;
        err  = bif.resp_err;
        lost = 1'b0;
        break;
      end
      @(negedge clk);
    end
    writes = wr_cnt - w0;
  endtask

  task automatic test_reset();
    logic [51:0] outs;
    HRESETn       = 1'b0;
    bif.req_valid = '1;
    #2;
    n_tests++;
    if (bif.req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0", bif.req_ready);
    end
    bif.req_valid = '0;
    do_reset();
    outs = {bif.req_ready, bif.mem_req_valid, bif.mem_req_rw,
            bif.mem_index, bif.mem_wdata, bif.resp_valid,
            bif.resp_port, bif.resp_pass, bif.resp_err,
            bif.check_risk, bif.send_order, bif.update_max};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (bif.mem_req_valid !== 1'b0 || bif.resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: memv %b resp %b want 0 0",
                 bif.mem_req_valid, bif.resp_valid);
      end
    end
  endtask

  task automatic test_directed();
    int          d_ch  [4] = '{0, 1, 2, 3};
    int          d_id  [4] = '{3, 5, 7, 9};
    logic [31:0] d_ram [4] = '{32'h0064_0028, 32'h0032_002D,
                               32'h000A_0019, 32'h0001_0005};
    logic [15:0] d_cnc [4] = '{16'd10, 16'd0, 16'd0, 16'd20};
    logic [15:0] d_amt [4] = '{16'd20, 16'd10, 16'd300, 16'd3};
    logic        d_max [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        d_pas [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] d_new [4] = '{32'h0064_003C, 32'h0032_002D,
                               32'h012C_0019, 32'h0001_0008};
    int g, cyc, wr, upd, snd;
    logic [2:0] port;
    logic pass, err;
    bit bad, lost;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      ch_id[d_ch[k]]  = IW'(d_id[k]);
      ch_amt[d_ch[k]] = d_amt[k];
      ch_max[d_ch[k]] = d_max[k];
      ram[d_id[k]]    = d_ram[k];
      run_txn(N'(1 << d_ch[k]), d_cnc[k], g, cyc, port,
              pass, err, wr, upd, snd, bad, lost);
      rr_model = (d_ch[k] + 1) % N;
      n_tests++;
      if (lost || g != d_ch[k]) begin
        n_fail++;
        $display("FAIL dir%0d_grant: got %0d lost %b want %0d",
                 k, g, lost, d_ch[k]);
      end
      n_tests++;
      if (port !== 3'(d_ch[k]) || pass !== d_pas[k]
          || err !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_resp: port %0d pass %b err %b want %0d %b 0",
                 k, port, pass, err, d_ch[k], d_pas[k]);
      end
      n_tests++;
      if (ram[d_id[k]] !== d_new[k]) begin
        n_fail++;
        $display("FAIL dir%0d_ram: got %h want %h",
                 k, ram[d_id[k]], d_new[k]);
      end
      n_tests++;
      if (wr != (d_pas[k] ? 1 : 0)) begin
        n_fail++;
        $display("FAIL dir%0d_writes: got %0d want %0d",
                 k, wr, d_pas[k] ? 1 : 0);
      end
      n_tests++;
      if (cyc != (d_pas[k] ? 4 : 3)) begin
        n_fail++;
        $display("FAIL dir%0d_latency: got %0d want %0d",
                 k, cyc, d_pas[k] ? 4 : 3);
      end
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL dir%0d_strobes: exclusivity got 1 want 0", k);
      end
      n_tests++;
      if (upd != (d_max[k] ? 1 : 0)
          || snd != ((!d_max[k] && d_pas[k]) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL dir%0d_flags: upd %0d snd %0d", k, upd, snd);
      end
    end
  endtask

  task automatic test_fairness();
    int  grants [5];
    int  ng;
    bit  multi, done;
    do_reset();
    lat = 0;
    for (int i = 0; i < N; i++) begin
      ch_id[i]  = IW'(i + 20);
      ch_amt[i] = 16'($urandom);
      ch_max[i] = 1'b1;
    end
    ng = 0;
    multi = 1'b0;
    @(negedge clk);
    drive_req('1, 16'd0);
    for (int c = 0; c < 200 && ng < 5; c++) begin
      #1;
      if ($countones(bif.req_ready) > 1) multi = 1'b1;
      for (int i = 0; i < N; i++)
        if (bif.req_ready[i]) begin
          grants[ng] = i;
          ng++;
        end
      @(negedge clk);
    end
    bif.req_valid = '0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (bif.resp_valid) done = 1'b1;
      @(negedge clk);
    end
    rr_model = 1;
    n_tests++;
    if (ng != 5 || !done) begin
      n_fail++;
      $display("FAIL fair_count: got %0d grants done %b want 5 1",
               ng, done);
    end
    n_tests++;
    if (multi) begin
      n_fail++;
      $display("FAIL fair_onehot: multiple ready got 1 want 0");
    end
    for (int k = 0; k < 5; k++) begin
      if (k < ng) begin
        n_tests++;
        if (grants[k] != k % N) begin
          n_fail++;
          $display("FAIL fair_grant%0d: got %0d want %0d",
                   k, grants[k], k % N);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    logic [15:0]  canc;
    logic [31:0]  old, nw;
    logic         ep;
    int eg, g, cyc, wr, upd, snd;
    logic [2:0] port;
    logic pass, err;
    bit bad, lost;
    for (int it = 0; it < 40; it++) begin
      lat  = $urandom_range(0, 3);
      m    = N'($urandom_range(1, (1 << N) - 1));
      canc = 16'($urandom_range(0, 16383));
      for (int i = 0; i < N; i++) begin
        ch_id[i]  = IW'($urandom_range(0, 31));
        ch_amt[i] = 16'($urandom_range(0, 16383));
        ch_max[i] = ($urandom_range(0, 3) == 0);
      end
      for (int i = 0; i < N; i++)
        ram[ch_id[i]] = {16'($urandom),
                         16'($urandom_range(0, 16383))};
      eg  = exp_grant(m);
      old = ram[ch_id[eg]];
      model(old, canc, ch_amt[eg], ch_max[eg], ep, nw);
      run_txn(m, canc, g, cyc, port, pass, err,
              wr, upd, snd, bad, lost);
      rr_model = (eg + 1) % N;
      n_tests++;
      if (lost || g != eg || port !== 3'(eg)) begin
        n_fail++;
        $display("FAIL rnd%0d_grant: got %0d port %0d lost %b want %0d",
                 it, g, port, lost, eg);
      end
      n_tests++;
      if (pass !== ep || err !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd%0d_pass: got %b err %b want %b 0",
                 it, pass, err, ep);
      end
      n_tests++;
      if (ram[ch_id[eg]] !== nw) begin
        n_fail++;
        $display("FAIL rnd%0d_ram: got %h want %h",
                 it, ram[ch_id[eg]], nw);
      end
      n_tests++;
      if (wr != (ep ? 1 : 0)) begin
        n_fail++;
        $display("FAIL rnd%0d_writes: got %0d want %0d",
                 it, wr, ep ? 1 : 0);
      end
      n_tests++;
      if (cyc != (ep ? 2 * lat + 4 : lat + 3)) begin
        n_fail++;
        $display("FAIL rnd%0d_latency: got %0d want %0d",
                 it, cyc, ep ? 2 * lat + 4 : lat + 3);
      end
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL rnd%0d_strobes: exclusivity got 1 want 0", it);
      end
    end
  endtask

  task automatic test_timeout();
    int g, cyc, wr, upd, snd;
    logic [2:0] port;
    logic pass, err;
    bit bad, lost, stray;
    logic [31:0] old;
    lat = 0;
    ram_en = 1'b0;
    ch_id[2] = 5'd4; ch_amt[2] = 16'd1; ch_max[2] = 1'b0;
    run_txn(4'b0100, 16'd0, g, cyc, port, pass, err,
            wr, upd, snd, bad, lost);
    rr_model = 3;
    ram_en = 1'b1;
    n_tests++;
    if (lost || err !== 1'b1 || pass !== 1'b0 || port !== 3'd2) begin
      n_fail++;
      $display("FAIL tmo_read_resp: err %b pass %b port %0d want 1 0 2",
               err, pass, port);
    end
    n_tests++;
    if (cyc != TMO + 1) begin
      n_fail++;
      $display("FAIL tmo_read_cycles: got %0d want %0d", cyc, TMO + 1);
    end
    wr_en = 1'b0;
    ch_id[1] = 5'd6; ch_amt[1] = 16'd77; ch_max[1] = 1'b1;
    ram[6] = 32'h1234_5678;
    old = ram[6];
    run_txn(4'b0010, 16'd0, g, cyc, port, pass, err,
            wr, upd, snd, bad, lost);
    rr_model = 2;
    wr_en = 1'b1;
    n_tests++;
    if (lost || err !== 1'b1 || pass !== 1'b0 || cyc != TMO + 3) begin
      n_fail++;
      $display("FAIL tmo_write: err %b pass %b cyc %0d want 1 0 %0d",
               err, pass, cyc, TMO + 3);
    end
    n_tests++;
    if (ram[6] !== old || wr != 0) begin
      n_fail++;
      $display("FAIL tmo_write_ram: got %h writes %0d want %h 0",
               ram[6], wr, old);
    end
    @(posedge clk);
    #2;
    inj_rd = 1'b1;
    inj_wr = 1'b1;
    @(posedge clk);
    #2;
    inj_rd = 1'b0;
    inj_wr = 1'b0;
    stray = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bif.mem_req_valid || bif.resp_valid || bif.check_risk)
        stray = 1'b1;
    end
    n_tests++;
    if (stray) begin
      n_fail++;
      $display("FAIL late_handshake: activity got 1 want 0");
    end
  endtask

  task automatic test_reset_mid_write();
    logic [51:0] outs;
    logic [31:0] old;
    int w0, g, cyc, wr, upd, snd;
    logic [2:0] port;
    logic pass, err;
    bit seen, got, stray, bad, lost;
    lat = 10;
    ch_id[0] = 5'd11; ch_amt[0] = 16'd999; ch_max[0] = 1'b1;
    ram[11] = 32'h0005_0006;
    old = ram[11];
    w0  = wr_cnt;
    got = 1'b0;
    @(negedge clk);
    drive_req(4'b0001, 16'd0);
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (bif.req_ready[0]) got = 1'b1;
      @(negedge clk);
    end
    bif.req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (bif.mem_req_valid && bif.mem_req_rw) seen = 1'b1;
      else @(negedge clk);
    end
    n_tests++;
    if (!got || !seen) begin
      n_fail++;
      $display("FAIL rstw_reach: grant %b write %b want 1 1", got, seen);
    end
    HRESETn = 1'b0;
    #1;
    outs = {bif.req_ready, bif.mem_req_valid, bif.mem_req_rw,
            bif.mem_index, bif.mem_wdata, bif.resp_valid,
            bif.resp_port, bif.resp_pass, bif.resp_err,
            bif.check_risk, bif.send_order, bif.update_max};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL rstw_outputs: got %h want 0", outs);
    end
    repeat (2) @(negedge clk);
    HRESETn  = 1'b1;
    rr_model = 0;
    lat      = 0;
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bif.mem_req_valid || bif.resp_valid) stray = 1'b1;
    end
    n_tests++;
    if (stray || ram[11] !== old || wr_cnt != w0) begin
      n_fail++;
      $display("FAIL rstw_abandon: stray %b ram %h want 0 %h",
               stray, ram[11], old);
    end
    for (int i = 0; i < N; i++) begin
      ch_id[i] = IW'(i + 12); ch_max[i] = 1'b1;
    end
    run_txn('1, 16'd0, g, cyc, port, pass, err,
            wr, upd, snd, bad, lost);
    n_tests++;
    if (lost || g != 0 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL rstw_pointer: got %0d pass %b want 0 1", g, pass);
    end
  endtask

  initial begin
    HRESETn              = 1'b1;
    bif.req_valid        = '0;
    bif.req_client_id    = '0;
    bif.req_amount       = '0;
    bif.req_is_max       = '0;
    bif.cancelled_orders = '0;
    for (int i = 0; i < 32; i++) ram[i] = '0;
    for (int i = 0; i < N; i++) begin
      ch_id[i] = '0; ch_amt[i] = '0; ch_max[i] = 1'b0;
    end
    #1;
    test_reset();
    test_directed();
    test_fairness();
    test_random();
    test_timeout();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/upstream_order_scheduler.md
Name: upstream_order_scheduler

Overview:
Arbitrates order and max-update requests from NUM_REQ client channels onto the single-ported upstream client RAM. Sequences one read-risk-check-write transaction at a time and reports a per-request pass/fail response. Sits between the order ingress channels and the upstream RAM. Replaces ad-hoc per-order sequencing with a clocked FSM, a round-robin grant and a memory watchdog.

Parameters:
NUM_REQ, 4, number of requesting channels (2..8)
IDX_W, 5, client index width
TIMEOUT_CYCLES, 16, max cycles waiting for a RAM handshake before abort

Ports:
clk  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-channel request valid
req_ready  out  NUM_REQ  per-channel accept; one-hot or zero
req_client_id  in  NUM_REQ*IDX_W  packed client ids, channel 0 in LSBs
req_amount  in  NUM_REQ*16  packed order amount / new max
req_is_max  in  NUM_REQ  1 = max update, 0 = order
cancelled_orders  in  16  downstream cancelled total for mem_index, valid during CHECK
mem_req_valid  out  1  RAM request strobe
mem_req_rw  out  1  1 = write, 0 = read
mem_index  out  IDX_W  RAM address
mem_wdata  out  32  write data: [31:16] max_to_trade, [15:0] accumulated_orders
mem_rdata  in  32  read data
mem_rd_ready  in  1  read data valid pulse
mem_written  in  1  write complete pulse
resp_valid  out  1  one-cycle response pulse
resp_port  out  3  channel being answered
resp_pass  out  1  1 = order accepted or max updated
resp_err  out  1  1 = RAM timeout abort
check_risk  out  1  high in CHECK
send_order  out  1  high in WRITE for an order
update_max  out  1  high in WRITE for a max update

Behaviour:
- Reset: FSM=IDLE, RR pointer=0, all outputs 0, latched request cleared. Reset mid-transaction abandons it; no response issued.
- Accept: in IDLE with any req_valid, grant the first valid channel at or after the RR pointer (wrapping). req_ready[g]=1 for exactly that cycle; latch id, amount, is_max. Pointer becomes g+1 mod NUM_REQ. Only one ready bit per cycle; ready=0 outside IDLE.
- READ: mem_req_valid=1, rw=0, mem_index=latched id; held until mem_rd_ready. Latch mem_rdata as acc=[15:0], max=[31:16].
- CHECK (exactly 1 cycle, check_risk=1), order:
  result = acc - cancelled_orders + amount, 16-bit modular.
  pass = $signed({1'b0,max}) > $signed(result), i.e. 17-bit signed compare.
- CHECK, max update: pass=1 unconditionally.
- WRITE:
  - Order with pass: wdata={max, acc+amount} (16-bit wrap).
  - Max update: wdata={amount, acc}.
  - mem_req_valid=1, rw=1; held until mem_written.
  - Order with pass=0 skips WRITE and goes straight to RESP.
  - send_order / update_max are mutually exclusive; never high together with check_risk.
- RESP (1 cycle): resp_valid=1 with resp_port=g and resp_pass; return to IDLE. Min transaction = 4 cycles plus RAM latency; the next grant is possible the cycle after RESP.
- Timeout: a counter resets on entering READ or WRITE. Reaching TIMEOUT_CYCLES with no handshake: drop mem_req_valid, go to RESP with resp_pass=0 and resp_err=1. A late handshake arriving in IDLE is ignored.
- Handshake pulses arriving in a state that does not expect them are ignored.
- Requesters hold valid and payload until ready. A channel dropping valid before grant is simply not granted.

Test Plan:
- Single order, ch0, id=3, RAM[3]={100,40}, cancelled=10, amount=20 -> result 50 < 100; write {100,60}; resp_pass=1, port 0.
- Risk fail, ch1, RAM[5]={50,45}, cancelled=0, amount=10 -> result 55 ≥ 50; no write strobe; resp_pass=0.
- Max update, ch2, id=7, amount=300, RAM[7]={10,25} -> write {300,25}; update_max high during WRITE only; resp_pass=1.
- Fairness: all 4 channels valid continuously -> grants 0,1,2,3,0 in order; at most one req_ready bit set at any time.
- Negative result: acc=5, cancelled=20, amount=3 (result 0xFFF4, i.e. −12), max=1 -> pass=1.
- Timeout: mem_rd_ready never asserted -> after 16 cycles resp_err=1 and resp_pass=0. HRESETn asserted mid-WRITE -> all outputs 0 immediately and the FSM is in IDLE.
